// File: rtl/audio_pkg.sv
// Shared types and gain helpers for the audio fade/mute gate.
package audio_pkg;

    typedef enum logic [2:0] {
        ST_MUTE     = 3'd0,
        ST_FADE_IN  = 3'd1,
        ST_RUN      = 3'd2,
        ST_FADE_OUT = 3'd3,
        ST_SILENT   = 3'd4
    } fade_state_t;

    localparam int DEFAULT_GAIN_BITS = 8;
    localparam int GAIN_W            = DEFAULT_GAIN_BITS + 1;
    localparam int UNITY_GAIN        = 1 << DEFAULT_GAIN_BITS;

    // Gain carries one extra bit so that unity (2^gain_bits) is representable.
    function automatic int gain_width(input int gain_bits);
        return gain_bits + 1;
    endfunction

    function automatic int unity_gain(input int gain_bits);
        return 1 << gain_bits;
    endfunction

endpackage

// File: rtl/audio_gain_mul.sv
// One channel: signed sample times unsigned gain, scaled back by 2^GAIN_BITS, registered.
module audio_gain_mul
    import audio_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int GAIN_BITS = DEFAULT_GAIN_BITS
) (
    input  logic                           clk_sys,
    input  logic                           reset,
    input  logic                           force_zero,
    input  logic [WIDTH-1:0]               sample,
    input  logic [gain_width(GAIN_BITS)-1:0] gain,
    output logic [WIDTH-1:0]               result
);

    localparam int GW = gain_width(GAIN_BITS);
    localparam int PW = WIDTH + GAIN_BITS + 1;

    logic signed [PW-1:0] sample_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] product;

    // The full product always fits in PW bits, so the shift back is exact at unity.
    assign sample_ext = {{(PW-WIDTH){sample[WIDTH-1]}}, sample};
    assign gain_ext   = {{(PW-GW){1'b0}}, gain};
    assign product    = sample_ext * gain_ext;

    always_ff @(posedge clk_sys) begin
        if (reset || force_zero) begin
            result <= '0;
        end else begin
            result <= WIDTH'(product >>> GAIN_BITS);
        end
    end

endmodule

// File: rtl/audio_fade_gate.sv
// Post-reset mute, then linear gain fade in/out around a runtime mute request.
module audio_fade_gate
    import audio_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 16,
    parameter int GAIN_BITS   = DEFAULT_GAIN_BITS,
    parameter int FADE_SHIFT  = 10,
    parameter int MUTE_CYCLES = 16777215
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      mute_req,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dout_en,
    output logic                      active
);

    localparam int GW = gain_width(GAIN_BITS);
    localparam logic [GW-1:0] UNITY = GW'(unity_gain(GAIN_BITS));

    localparam int PW = (FADE_SHIFT > 0) ? FADE_SHIFT : 1;
    localparam logic [PW-1:0] PRESC_MAX = (FADE_SHIFT > 0) ? {PW{1'b1}} : '0;

    localparam int CW = $clog2(MUTE_CYCLES + 1);
    localparam logic [CW-1:0] MUTE_LAST = CW'(MUTE_CYCLES - 1);

    fade_state_t     state, state_next;
    logic [GW-1:0]   gain, gain_next;
    logic [CW-1:0]   mute_cnt, mute_cnt_next;
    logic [PW-1:0]   presc, presc_next;
    logic            presc_wrap;
    logic            in_mute;

    assign presc_wrap = (presc == PRESC_MAX);
    assign in_mute    = (state == ST_MUTE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= ST_MUTE;
            gain     <= '0;
            mute_cnt <= '0;
            presc    <= '0;
            dout_en  <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= state_next;
            gain     <= gain_next;
            mute_cnt <= mute_cnt_next;
            presc    <= presc_next;
            dout_en  <= (state_next != ST_MUTE);
            active   <= (state_next == ST_RUN);
        end
    end

    always_comb begin
        state_next    = state;
        gain_next     = gain;
        mute_cnt_next = mute_cnt;
        presc_next    = presc;

        if (ce) begin
            case (state)
                ST_MUTE: begin
                    gain_next = '0;
                    if (mute_cnt == MUTE_LAST) begin
                        mute_cnt_next = '0;
                        state_next    = mute_req ? ST_SILENT : ST_FADE_IN;
                    end else begin
                        mute_cnt_next = mute_cnt + CW'(1);
                    end
                end

                // A reversal mid-fade keeps the gain so the ramp never jumps.
                ST_FADE_IN: begin
                    if (mute_req) begin
                        state_next = ST_FADE_OUT;
                    end else if (gain >= UNITY) begin
                        gain_next  = UNITY;
                        state_next = ST_RUN;
                    end else begin
                        presc_next = presc_wrap ? '0 : presc + PW'(1);
                        if (presc_wrap) begin
                            gain_next = gain + GW'(1);
                            if (gain + GW'(1) == UNITY) begin
                                state_next = ST_RUN;
                            end
                        end
                    end
                end

                ST_RUN: begin
                    gain_next = UNITY;
                    if (mute_req) begin
                        state_next = ST_FADE_OUT;
                    end
                end

                ST_FADE_OUT: begin
                    if (!mute_req) begin
                        state_next = ST_FADE_IN;
                    end else if (gain == '0) begin
                        state_next = ST_SILENT;
                    end else begin
                        presc_next = presc_wrap ? '0 : presc + PW'(1);
                        if (presc_wrap) begin
                            gain_next = gain - GW'(1);
                            if (gain == GW'(1)) begin
                                state_next = ST_SILENT;
                            end
                        end
                    end
                end

                ST_SILENT: begin
                    gain_next = '0;
                    if (!mute_req) begin
                        state_next = ST_FADE_IN;
                    end
                end

                default: begin
                    state_next    = ST_MUTE;
                    gain_next     = '0;
                    mute_cnt_next = '0;
                end
            endcase

            if (state_next != state) begin
                presc_next = '0;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        audio_gain_mul #(
            .WIDTH     (WIDTH),
            .GAIN_BITS (GAIN_BITS)
        ) u_mul (
            .clk_sys    (clk_sys),
            .reset      (reset),
            .force_zero (in_mute),
            .sample     (din[c*WIDTH +: WIDTH]),
            .gain       (gain),
            .result     (dout[c*WIDTH +: WIDTH])
        );
    end

endmodule
